// File: rtl/bip_sequencer.sv
// Multi-cycle control sequencer for the accumulator CPU.
// Owns the PC, the instruction register and the fetch/decode/execute FSM.
// It also handles variable data-RAM read latency, halt and illegal-opcode
// trapping, single-step debug mode and a saturating retired-instruction count.
//
// Handshake semantics: there is no valid/ready pairing here. Instruction
// memory is a plain synchronous read: i_instr reflects o_pc one cycle later.
// Every strobe output is a registered single-cycle pulse; o_rd_ram is the
// exception and stays high for 1+RAM_LAT cycles.
//
// Debug: o_state exposes the FSM state encoding.
// IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEMWAIT=4 HALT=5.
module bip_sequencer #(
  parameter int OPCODE_W  = 5,
  parameter int OPERAND_W = 11,
  parameter int PC_W      = 11,
  parameter int RAM_LAT   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic                          i_run,
  input  logic                          i_step_mode,
  input  logic                          i_step,
  input  logic [OPCODE_W+OPERAND_W-1:0] i_instr,
  output logic [PC_W-1:0]               o_pc,
  output logic [OPERAND_W-1:0]          o_operand,
  output logic [1:0]                    o_sel_a,
  output logic                          o_sel_b,
  output logic                          o_op,
  output logic                          o_wr_acc,
  output logic                          o_wr_ram,
  output logic                          o_rd_ram,
  output logic                          o_wr_pc,
  output logic                          o_halted,
  output logic                          o_illegal,
  output logic [CNT_W-1:0]              o_retired,
  output logic [2:0]                    o_state
);

  localparam int INSTR_W = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STO  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(7);

  // Index of the final MEMWAIT cycle (RAM_LAT is 1..4, so 3 bits suffice).
  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    MEMWAIT = 3'd4,
    HALT    = 3'd5
  } state_t;

  state_t              state;
  state_t              retireNext;
  logic [OPCODE_W-1:0] irOp;
  logic [OPCODE_W-1:0] fetchedOp;
  logic [2:0]          waitCnt;
  logic                startReq;

  // Memory-operand instructions hold their mux/op setting while RAM data arrives.
  // The returned value is packed as {sel_a, sel_b, op}.
  function automatic logic [3:0] memCtl(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LD:   memCtl = 4'b0010;
      OP_ADD:  memCtl = 4'b1001;
      default: memCtl = 4'b1000;
    endcase
  endfunction

  assign fetchedOp  = i_instr[INSTR_W-1 -: OPCODE_W];
  assign startReq   = i_step_mode ? i_step : i_run;
  assign retireNext = (i_run && !i_step_mode) ? FETCH : IDLE;
  assign o_state    = state;

  // Sequencer FSM. Outputs are computed on entry to a state, so the strobes
  // are registered and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      o_pc      <= '0;
      irOp      <= '0;
      o_operand <= '0;
      waitCnt   <= '0;
      o_retired <= '0;
      o_sel_a   <= 2'b00;
      o_sel_b   <= 1'b0;
      o_op      <= 1'b0;
      o_wr_acc  <= 1'b0;
      o_wr_ram  <= 1'b0;
      o_rd_ram  <= 1'b0;
      o_wr_pc   <= 1'b0;
      o_halted  <= 1'b0;
      o_illegal <= 1'b0;
    end else if (i_clear) begin
      state     <= IDLE;
      o_pc      <= '0;
      irOp      <= '0;
      o_operand <= '0;
      waitCnt   <= '0;
      o_retired <= '0;
      o_sel_a   <= 2'b00;
      o_sel_b   <= 1'b0;
      o_op      <= 1'b0;
      o_wr_acc  <= 1'b0;
      o_wr_ram  <= 1'b0;
      o_rd_ram  <= 1'b0;
      o_wr_pc   <= 1'b0;
      o_halted  <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      o_sel_a  <= 2'b00;
      o_sel_b  <= 1'b0;
      o_op     <= 1'b0;
      o_wr_acc <= 1'b0;
      o_wr_ram <= 1'b0;
      o_rd_ram <= 1'b0;
      o_wr_pc  <= 1'b0;

      // The retire cycle is the one that is ending with wr_pc high.
      if (o_wr_pc) begin
        o_pc <= o_pc + PC_W'(1);
        if (o_retired != '1) o_retired <= o_retired + CNT_W'(1);
      end

      case (state)
        IDLE: if (startReq) state <= FETCH;

        FETCH: state <= DECODE;

        DECODE: begin
          irOp      <= fetchedOp;
          o_operand <= i_instr[OPERAND_W-1:0];
          state     <= EXEC;
          case (fetchedOp)
            OP_STO: begin
              o_wr_ram <= 1'b1;
              o_sel_b  <= 1'b1;
              o_wr_pc  <= 1'b1;
            end
            OP_LDI: begin
              o_sel_a  <= 2'b01;
              o_wr_acc <= 1'b1;
              o_wr_pc  <= 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
              o_sel_a  <= 2'b10;
              o_sel_b  <= 1'b1;
              o_op     <= (fetchedOp == OP_ADDI);
              o_wr_acc <= 1'b1;
              o_wr_pc  <= 1'b1;
            end
            OP_LD, OP_ADD, OP_SUB: o_rd_ram <= 1'b1;
            default: ;
          endcase
        end

        EXEC: begin
          case (irOp)
            OP_HALT: begin
              state    <= HALT;
              o_halted <= 1'b1;
            end
            OP_STO, OP_LDI, OP_ADDI, OP_SUBI: state <= retireNext;
            OP_LD, OP_ADD, OP_SUB: begin
              state   <= MEMWAIT;
              waitCnt <= '0;
              o_rd_ram <= 1'b1;
              {o_sel_a, o_sel_b, o_op} <= memCtl(irOp);
              if (LAT_LAST == 3'd0) begin
                o_wr_acc <= 1'b1;
                o_wr_pc  <= 1'b1;
              end
            end
            default: begin
              state     <= HALT;
              o_halted  <= 1'b1;
              o_illegal <= 1'b1;
            end
          endcase
        end

        MEMWAIT: begin
          if (waitCnt == LAT_LAST) begin
            state <= retireNext;
          end else begin
            waitCnt  <= waitCnt + 3'd1;
            o_rd_ram <= 1'b1;
            {o_sel_a, o_sel_b, o_op} <= memCtl(irOp);
            if (waitCnt + 3'd1 == LAT_LAST) begin
              o_wr_acc <= 1'b1;
              o_wr_pc  <= 1'b1;
            end
          end
        end

        HALT: state <= HALT;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_sequencer.sv
// Bench for bip_sequencer. Configuration: RAM_LAT=3, PC_W=3, CNT_W=2.
// An instruction-level reference model expands each program into an
// expected per-cycle output trace. Directed tasks cover stepping,
// run-drop behaviour and asynchronous reset.
module tb_bip_sequencer;

  localparam int LAT = 3;
  localparam int W   = 26;

  logic        clk;
  logic        rst_n;
  logic        i_clear;
  logic        i_run;
  logic        i_step_mode;
  logic        i_step;
  logic [15:0] i_instr;
  logic [2:0]  o_pc;
  logic [10:0] o_operand;
  logic [1:0]  o_sel_a;
  logic        o_sel_b;
  logic        o_op;
  logic        o_wr_acc;
  logic        o_wr_ram;
  logic        o_rd_ram;
  logic        o_wr_pc;
  logic        o_halted;
  logic        o_illegal;
  logic [1:0]  o_retired;
  logic [2:0]  dbgState;

  logic [15:0]  imem[8];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obsVec;
  int           nCmp = 0;
  int           nBad = 0;

  bip_sequencer #(
    .OPCODE_W(5), .OPERAND_W(11), .PC_W(3), .RAM_LAT(LAT), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_run(i_run),
    .i_step_mode(i_step_mode), .i_step(i_step), .i_instr(i_instr),
    .o_pc(o_pc), .o_operand(o_operand), .o_sel_a(o_sel_a), .o_sel_b(o_sel_b),
    .o_op(o_op), .o_wr_acc(o_wr_acc), .o_wr_ram(o_wr_ram), .o_rd_ram(o_rd_ram),
    .o_wr_pc(o_wr_pc), .o_halted(o_halted), .o_illegal(o_illegal),
    .o_retired(o_retired), .o_state(dbgState)
  );

  assign obsVec = {o_pc, o_operand, o_sel_a, o_sel_b, o_op, o_wr_acc, o_wr_ram,
                   o_rd_ram, o_wr_pc, o_halted, o_illegal, o_retired};

  // Clock and instruction memory (synchronous read)
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) i_instr <= imem[o_pc];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] vec(input logic [2:0] pc, input logic [10:0] opd,
      input logic [1:0] sa, input logic sb, input logic aop, input logic wa,
      input logic wr, input logic rd, input logic wp, input logic h,
      input logic il, input logic [1:0] ret);
    vec = {pc, opd, sa, sb, aop, wa, wr, rd, wp, h, il, ret};
  endfunction

  // Reference model: walk the program instruction by instruction from a cleared state
  task automatic model_trace(input int ncyc);
    logic [2:0]  pc;
    logic [1:0]  ret;
    logic [10:0] opd;
    logic [4:0]  op;
    logic [1:0]  sa;
    logic        sb, aop, retire;
    bit          halted, ill;
    pc = 0; ret = 0; opd = 0; halted = 0; ill = 0;
    exp_q.delete();
    while (exp_q.size() < ncyc) begin
      if (halted) begin
        exp_q.push_back(vec(pc, opd, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ill, ret));
        continue;
      end
      exp_q.push_back(vec(pc, opd, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ret));
      exp_q.push_back(vec(pc, opd, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ret));
      op = imem[pc][15:11];
      opd = imem[pc][10:0];
      retire = 1'b1;
      case (op)
        5'd1: exp_q.push_back(vec(pc, opd, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ret));
        5'd3: exp_q.push_back(vec(pc, opd, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ret));
        5'd5: exp_q.push_back(vec(pc, opd, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ret));
        5'd7: exp_q.push_back(vec(pc, opd, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ret));
        5'd2, 5'd4, 5'd6: begin
          sa  = (op == 5'd2) ? 2'b00 : 2'b10;
          sb  = (op == 5'd2);
          aop = (op == 5'd4);
          exp_q.push_back(vec(pc, opd, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ret));
          for (int k = 0; k < LAT; k++)
            exp_q.push_back(vec(pc, opd, sa, sb, aop, k == LAT - 1, 1'b0, 1'b1, k == LAT - 1,
                                1'b0, 1'b0, ret));
        end
        default: begin
          exp_q.push_back(vec(pc, opd, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ret));
          halted = 1;
          ill    = (op != 5'd0);
          retire = 1'b0;
        end
      endcase
      if (retire) begin
        pc = pc + 3'd1;
        if (ret != 2'b11) ret = ret + 2'd1;
      end
    end
    while (exp_q.size() > ncyc) void'(exp_q.pop_back());
  endtask

  // Driver tasks
  task automatic clear_dut;
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic start_run;
    i_step_mode = 1'b0;
    i_run = 1'b0;
    clear_dut();
    i_run = 1'b1;
  endtask

  // Scoreboard: compare each cycle against the model queue
  task automatic compare_trace(input string name, input int ncyc,
                               output int rdCnt, output int accCnt);
    logic [W-1:0] expv;
    rdCnt = 0;
    accCnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      i_step = 1'($urandom_range(0, 1));
      nCmp++;
      if (exp_q.size() == 0) begin
        nBad++;
        $display("FAIL %s cycle %0d: model queue empty, got %h", name, c, obsVec);
      end else begin
        expv = exp_q.pop_front();
        if (obsVec !== expv) begin
          nBad++;
          $display("FAIL %s cycle %0d: got %h want %h", name, c, obsVec, expv);
        end
      end
      rdCnt += int'(o_rd_ram);
      accCnt += int'(o_wr_acc);
    end
    i_step = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_trace(input string name, input int ncyc, output int rdCnt, output int accCnt);
    start_run();
    model_trace(ncyc);
    compare_trace(name, ncyc, rdCnt, accCnt);
    i_run = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_clear = 1'b0; i_run = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    for (int i = 0; i < 8; i++) imem[i] = 16'h0;
    #12;
    nCmp++;
    if (obsVec !== '0 || dbgState !== 3'd0) begin
      nBad++;
      $display("FAIL reset: got %h state %0d want 0 state 0", obsVec, dbgState);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_program;
    int rd, acc;
    imem[0] = {5'd3, 11'd5};
    imem[1] = {5'd5, 11'd3};
    imem[2] = {5'd1, 11'd7};
    imem[3] = {5'd0, 11'd0};
    for (int i = 4; i < 8; i++) imem[i] = 16'h0;
    run_trace("program", 15, rd, acc);
    nCmp++;
    if (o_halted !== 1'b1 || o_pc !== 3'd3 || o_retired !== 2'd3 || acc != 2) begin
      nBad++;
      $display("FAIL program_end: halted %b pc %0d retired %0d accw %0d want 1 3 3 2",
               o_halted, o_pc, o_retired, acc);
    end
  endtask

  task automatic test_mem_add;
    int rd, acc;
    imem[0] = {5'd4, 11'd4};
    imem[1] = {5'd0, 11'd0};
    run_trace("mem_add", 14, rd, acc);
    nCmp++;
    if (rd != 4 || acc != 1) begin
      nBad++;
      $display("FAIL mem_add_counts: rd_ram cycles %0d wr_acc %0d want 4 1", rd, acc);
    end
  endtask

  task automatic test_illegal;
    int rd, acc;
    imem[0] = {5'b01111, 11'h055};
    run_trace("illegal", 8, rd, acc);
    nCmp++;
    if (o_illegal !== 1'b1 || o_halted !== 1'b1 || o_pc !== 3'd0) begin
      nBad++;
      $display("FAIL illegal_flags: illegal %b halted %b pc %0d want 1 1 0", o_illegal, o_halted, o_pc);
    end
    clear_dut();
    nCmp++;
    if (obsVec !== '0 || dbgState !== 3'd0) begin
      nBad++;
      $display("FAIL illegal_clear: got %h state %0d want 0 state 0", obsVec, dbgState);
    end
  endtask

  task automatic test_wrap;
    int rd, acc;
    for (int i = 0; i < 8; i++) imem[i] = {5'd3, 11'(i + 100)};
    start_run();
    model_trace(27);
    compare_trace("wrap", 27, rd, acc);
    @(negedge clk);
    i_run = 1'b0;
    nCmp++;
    if (o_pc !== 3'd1 || o_retired !== 2'd3) begin
      nBad++;
      $display("FAIL wrap_end: pc %0d retired %0d want 1 3", o_pc, o_retired);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random;
    int rd, acc;
    logic [4:0] op;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 15))
          0:       op = 5'd0;
          1:       op = 5'd15;
          default: op = 5'($urandom_range(1, 7));
        endcase
        imem[i] = {op, 11'($urandom_range(0, 2047))};
      end
      run_trace("random", 60, rd, acc);
    end
  endtask

  task automatic test_step;
    int wr;
    for (int i = 0; i < 8; i++) imem[i] = {5'd3, 11'(i)};
    i_run = 1'b0;
    i_step_mode = 1'b1;
    clear_dut();
    for (int p = 0; p < 2; p++) begin
      wr = 0;
      i_step = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        i_step = (c == 1);
        wr += int'(o_wr_pc);
      end
      nCmp++;
      if (wr != 1 || dbgState !== 3'd0) begin
        nBad++;
        $display("FAIL step_%0d: retires %0d state %0d want 1 state 0", p, wr, dbgState);
      end
    end
    nCmp++;
    if (o_retired !== 2'd2 || o_pc !== 3'd2) begin
      nBad++;
      $display("FAIL step_total: retired %0d pc %0d want 2 2", o_retired, o_pc);
    end
    i_step_mode = 1'b0;
  endtask

  task automatic test_run_drop;
    int wr;
    for (int i = 0; i < 8; i++) imem[i] = {5'd3, 11'(i)};
    start_run();
    repeat (4) @(negedge clk);
    i_run = 1'b0;
    wr = 0;
    repeat (6) begin
      @(negedge clk);
      wr += int'(o_wr_pc);
    end
    nCmp++;
    if (wr != 1 || dbgState !== 3'd0 || o_pc !== 3'd2 || o_retired !== 2'd2) begin
      nBad++;
      $display("FAIL run_drop: retires %0d state %0d pc %0d retired %0d want 1 0 2 2",
               wr, dbgState, o_pc, o_retired);
    end
  endtask

  task automatic test_async_reset;
    bit accSeen;
    accSeen = 0;
    imem[0] = {5'd4, 11'd4};
    imem[1] = {5'd0, 11'd0};
    start_run();
    repeat (5) begin
      @(negedge clk);
      if (o_wr_acc) accSeen = 1;
    end
    nCmp++;
    if (dbgState !== 3'd4 || o_rd_ram !== 1'b1) begin
      nBad++;
      $display("FAIL async_pre: state %0d rd_ram %b want 4 1", dbgState, o_rd_ram);
    end
    #2 rst_n = 1'b0;
    #1;
    nCmp++;
    if (obsVec !== '0 || dbgState !== 3'd0) begin
      nBad++;
      $display("FAIL async_reset: got %h state %0d want 0 state 0", obsVec, dbgState);
    end
    repeat (3) begin
      @(negedge clk);
      if (o_wr_acc) accSeen = 1;
    end
    nCmp++;
    if (accSeen) begin
      nBad++;
      $display("FAIL async_no_write: wr_acc seen 1 want 0");
    end
    i_run = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_program();
    test_mem_add();
    test_illegal();
    test_wrap();
    test_step();
    test_run_drop();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
